// File: rtl/rx_crc_chk_pkg.sv
// Shared widths, polynomial and FSM encoding for the receive CRC checker
// and its serial divider.
package rx_crc_chk_pkg;

  localparam int DATA_LENGTH   = 8;
  localparam int CRC_LENGTH    = 8;
  localparam int CW_LENGTH     = DATA_LENGTH + CRC_LENGTH;
  localparam int CNT_WIDTH     = 4;
  localparam int ERR_CNT_WIDTH = 8;

  localparam logic [CRC_LENGTH-1:0] CRC_POLY = 8'h07;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_CALC = 2'd1,
    RX_CHK  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_crc_chk_div.sv
// Serial mod-2 divider: holds {data, zeros} and performs one long-division
// step per cycle; the upper CRC bits are the running remainder.
module crc_serial_div
  import rx_crc_chk_pkg::*;
#(
  parameter int                DW   = DATA_LENGTH,
  parameter int                CW   = CRC_LENGTH,
  parameter logic [CW-1:0]     POLY = CRC_POLY
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [DW-1:0] data_i,
  output logic [CW-1:0] rem_o
);

  logic [DW+CW-1:0] div_q;
  logic [DW+CW-1:0] div_d;

  always_comb begin
    div_d = div_q;
    if (load_i) begin
      div_d = {data_i, {CW{1'b0}}};
    end else if (step_i) begin
      // MSB drops out; subtract the polynomial when it was set
      div_d[DW+CW-1:DW] = div_q[DW+CW-2:DW-1]
                        ^ (div_q[DW+CW-1] ? POLY : '0);
      div_d[DW-1:0]     = {div_q[DW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

  assign rem_o = div_q[DW+CW-1:DW];

endmodule

// File: rtl/rx_crc_chk.sv
// Receive CRC checker: recomputes the CRC over the data field serially,
// reports the syndrome and keeps a saturating error count.
module rx_crc_chk
  import rx_crc_chk_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CW_LENGTH-1:0]     rx_crc_i,
  input  logic                     rx_crc_start,
  input  logic                     rx_err_clr,
  output logic                     rx_crc_busy,
  output logic                     rx_crc_vld,
  output logic                     rx_crc_ok,
  output logic                     rx_crc_err,
  output logic [CRC_LENGTH-1:0]    rx_crc_syn,
  output logic [DATA_LENGTH-1:0]   rx_crc_data,
  output logic [ERR_CNT_WIDTH-1:0] rx_err_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(DATA_LENGTH - 1);

  rx_state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [CRC_LENGTH-1:0]    crc_rx_q, crc_rx_d;
  logic [DATA_LENGTH-1:0]   hold_q, hold_d;
  logic                     vld_q, vld_d;
  logic                     ok_q, ok_d;
  logic                     err_q, err_d;
  logic [CRC_LENGTH-1:0]    syn_q, syn_d;
  logic [DATA_LENGTH-1:0]   data_q, data_d;
  logic [ERR_CNT_WIDTH-1:0] ecnt_q, ecnt_d;

  logic                     load;
  logic                     step;
  logic [CRC_LENGTH-1:0]    rem;
  logic [CRC_LENGTH-1:0]    syn_w;
  logic                     chk;
  logic                     fail;

  crc_serial_div u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .step_i (step),
    .data_i (rx_crc_i[CW_LENGTH-1:CRC_LENGTH]),
    .rem_o  (rem)
  );

  assign chk   = (state_q == RX_CHK);
  assign syn_w = rem ^ crc_rx_q;
  assign fail  = chk && (syn_w != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    crc_rx_d = crc_rx_q;
    hold_d   = hold_q;
    vld_d    = 1'b0;
    ok_d     = ok_q;
    err_d    = err_q;
    syn_d    = syn_q;
    data_d   = data_q;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (rx_crc_start) begin
          load     = 1'b1;
          cnt_d    = '0;
          crc_rx_d = rx_crc_i[CRC_LENGTH-1:0];
          hold_d   = rx_crc_i[CW_LENGTH-1:CRC_LENGTH];
          state_d  = RX_CALC;
        end
      end
      RX_CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = RX_CHK;
      end
      RX_CHK: begin
        state_d = RX_IDLE;
        vld_d   = 1'b1;
        syn_d   = syn_w;
        ok_d    = (syn_w == '0);
        err_d   = (syn_w != '0);
        data_d  = hold_q;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // A clear that coincides with a failing result keeps that one error
  always_comb begin
    ecnt_d = ecnt_q;
    if (rx_err_clr)
      ecnt_d = {{(ERR_CNT_WIDTH-1){1'b0}}, fail};
    else if (fail && !(&ecnt_q))
      ecnt_d = ecnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      crc_rx_q <= '0;
      hold_q   <= '0;
      vld_q    <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      syn_q    <= '0;
      data_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      crc_rx_q <= crc_rx_d;
      hold_q   <= hold_d;
      vld_q    <= vld_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      syn_q    <= syn_d;
      data_q   <= data_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign rx_crc_busy = (state_q != RX_IDLE);
  assign rx_crc_vld  = vld_q;
  assign rx_crc_ok   = ok_q;
  assign rx_crc_err  = err_q;
  assign rx_crc_syn  = syn_q;
  assign rx_crc_data = data_q;
  assign rx_err_cnt  = ecnt_q;

endmodule

// File: tb/tb_rx_crc_chk.sv
// Randomized and directed bench for rx_crc_chk against a cycle-level
// behavioural model built on a direct-form CRC.
module tb_rx_crc_chk;
  import rx_crc_chk_pkg::*;

  localparam int D = DATA_LENGTH;
  localparam int C = CRC_LENGTH;
  localparam int E = ERR_CNT_WIDTH;

  logic                 clk;
  logic                 rst_n;
  logic [CW_LENGTH-1:0] rx_crc_i;
  logic                 rx_crc_start;
  logic                 rx_err_clr;
  logic                 rx_crc_busy;
  logic                 rx_crc_vld;
  logic                 rx_crc_ok;
  logic                 rx_crc_err;
  logic [C-1:0]         rx_crc_syn;
  logic [D-1:0]         rx_crc_data;
  logic [E-1:0]         rx_err_cnt;

  rx_crc_chk dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_crc_i     (rx_crc_i),
    .rx_crc_start (rx_crc_start),
    .rx_err_clr   (rx_err_clr),
    .rx_crc_busy  (rx_crc_busy),
    .rx_crc_vld   (rx_crc_vld),
    .rx_crc_ok    (rx_crc_ok),
    .rx_crc_err   (rx_crc_err),
    .rx_crc_syn   (rx_crc_syn),
    .rx_crc_data  (rx_crc_data),
    .rx_err_cnt   (rx_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nt = 0;
  int nf = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nt++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Direct-form CRC: feed data MSB first into the register
  function automatic logic [C-1:0] ref_crc(input logic [D-1:0] d);
    logic [C-1:0] c;
    logic         fb;
    c = '0;
    for (int i = D - 1; i >= 0; i--) begin
      fb = c[C-1] ^ d[i];
      c  = {c[C-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

  function automatic logic [CW_LENGTH-1:0] mk(input logic [D-1:0] d,
                                              input logic good);
    logic [C-1:0] bad;
    bad = C'($urandom_range(1, (1 << C) - 1));
    return {d, ref_crc(d) ^ (good ? '0 : bad)};
  endfunction

  // Model: an accepted word produces its result D+1 edges later
  int                   m_left;
  logic [CW_LENGTH-1:0] m_word;
  logic                 m_vld, m_ok, m_err;
  logic [C-1:0]         m_syn;
  logic [D-1:0]         m_data;
  int                   m_cnt;
  logic                 evt, bad_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_word = '0; m_vld = 0; m_ok = 0; m_err = 0;
      m_syn = '0; m_data = '0; m_cnt = 0;
    end else begin
      evt   = (m_left == 1);
      m_vld = 1'b0;
      if (m_left > 0) m_left--;
      else if (rx_crc_start) begin
        m_left = D + 1;
        m_word = rx_crc_i;
      end
      bad_res = 1'b0;
      if (evt) begin
        m_syn   = ref_crc(m_word[CW_LENGTH-1:C]) ^ m_word[C-1:0];
        m_ok    = (m_syn == 0);
        m_err   = (m_syn != 0);
        m_data  = m_word[CW_LENGTH-1:C];
        m_vld   = 1'b1;
        bad_res = m_err;
      end
      if (rx_err_clr) m_cnt = bad_res ? 1 : 0;
      else if (bad_res && m_cnt < (1 << E) - 1) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(rx_crc_busy), 32'(m_left > 0));
      check("vld",  32'(rx_crc_vld),  32'(m_vld));
      check("ok",   32'(rx_crc_ok),   32'(m_ok));
      check("err",  32'(rx_crc_err),  32'(m_err));
      check("syn",  32'(rx_crc_syn),  32'(m_syn));
      check("data", 32'(rx_crc_data), 32'(m_data));
      check("ecnt", 32'(rx_err_cnt),  32'(m_cnt));
    end
  end

  // Caller sits at a negedge; lat counts negedges until vld is seen
  task automatic run_word(input logic [CW_LENGTH-1:0] w, input int inj_at,
                          input logic [CW_LENGTH-1:0] inj_w,
                          input int clr_at, output int lat);
    rx_crc_start = 1'b1;
    rx_crc_i     = w;
    lat          = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      rx_crc_start = (lat == inj_at);
      if (lat == inj_at) rx_crc_i = inj_w;
      rx_err_clr = (lat == clr_at);
      if (rx_crc_vld) break;
      if (lat > 40) begin
        nt++; nf++;
        $display("FAIL vld_timeout: no vld after %0d cycles", lat);
        break;
      end
    end
    rx_crc_start = 1'b0;
    rx_err_clr   = 1'b0;
  endtask

  int  lat;
  logic saw;

  initial begin
    rst_n = 0; rx_crc_i = '0; rx_crc_start = 0; rx_err_clr = 0;
    check("ref_01", 32'(ref_crc(8'h01)), 32'h07);
    check("ref_ff", 32'(ref_crc(8'hFF)), 32'hF3);
    check("ref_00", 32'(ref_crc(8'h00)), 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_busy", 32'(rx_crc_busy), 0);
    check("rst_out", 32'({rx_crc_vld, rx_crc_ok, rx_crc_err, rx_crc_syn,
                          rx_crc_data, rx_err_cnt}), 0);
    chk_en = 1'b1;

    run_word(16'h0107, 0, '0, 0, lat);
    check("t2_lat", 32'(lat), 10);
    check("t2_ok", 32'({rx_crc_ok, rx_crc_err}), 32'b10);
    check("t2_syn", 32'(rx_crc_syn), 32'h00);
    check("t2_data", 32'(rx_crc_data), 32'h01);
    check("t2_cnt", 32'(rx_err_cnt), 0);

    @(negedge clk);
    run_word(16'hFFF3, 0, '0, 0, lat);
    check("t3a_ok", 32'(rx_crc_ok), 1);
    run_word(16'h0106, 0, '0, 0, lat);
    check("t3b_err", 32'(rx_crc_err), 1);
    check("t3b_syn", 32'(rx_crc_syn), 32'h01);
    check("t3b_cnt", 32'(rx_err_cnt), 1);

    @(negedge clk);
    run_word(16'h5A00, 3, 16'h0107, 0, lat);
    check("t4_lat", 32'(lat), 10);
    check("t4_data", 32'(rx_crc_data), 32'h5A);
    run_word(16'hFFF3, 0, '0, 0, lat);
    check("t4_b2b_lat", 32'(lat), 10);
    check("t4_b2b_data", 32'(rx_crc_data), 32'hFF);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rx_crc_start = ($urandom_range(0, 2) == 0);
      rx_crc_i     = mk(D'($urandom), $urandom_range(0, 1) == 1);
      rx_err_clr   = ($urandom_range(0, 39) == 0);
    end
    rx_crc_start = 0; rx_err_clr = 0;
    repeat (15) @(negedge clk);

    rx_err_clr = 1;
    @(negedge clk);
    rx_err_clr = 0;
    check("clr_cnt", 32'(rx_err_cnt), 0);
    for (int i = 0; i < 255; i++)
      run_word(mk(D'($urandom), 1'b0), 0, '0, 0, lat);
    check("sat_255", 32'(rx_err_cnt), 32'hFF);
    run_word(mk(D'($urandom), 1'b0), 0, '0, 0, lat);
    check("sat_hold", 32'(rx_err_cnt), 32'hFF);
    run_word(mk(8'h3C, 1'b0), 0, '0, 9, lat);
    check("clr_err", 32'(rx_err_cnt), 1);
    run_word(mk(8'hC3, 1'b1), 0, '0, 9, lat);
    check("clr_pass", 32'(rx_err_cnt), 0);

    @(negedge clk);
    rx_crc_start = 1; rx_crc_i = 16'hABCD;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      rx_crc_start = 0;
    end
    #2 rst_n = 0;
    #1;
    check("t6_busy", 32'(rx_crc_busy), 0);
    check("t6_out", 32'({rx_crc_vld, rx_crc_ok, rx_crc_err, rx_crc_syn,
                         rx_crc_data, rx_err_cnt}), 0);
    @(negedge clk);
    rst_n = 1;
    saw = 0;
    repeat (15) begin
      @(negedge clk);
      if (rx_crc_vld) saw = 1;
    end
    check("t6_novld", 32'(saw), 0);
    run_word(16'h0000, 0, '0, 0, lat);
    check("t6_ok", 32'(rx_crc_ok), 1);
    check("t6_lat", 32'(lat), 10);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule

// File: doc/rx_crc_chk.md
# rx_crc_chk

Receive-side CRC checker, the counterpart of the transmit CRC generator. It accepts one received codeword: DATA_LENGTH data bits followed by a CRC_LENGTH CRC field. It recomputes the CRC serially over the data, one bit per clock, with the same polynomial and bit order as the transmit side. It then reports pass/fail with the syndrome and maintains a saturating error count for link monitoring.

## Interface
Configuration comes from the shared `para.v` macros.
- `DATA_LENGTH`, from `para.v`: payload bits per codeword.
- `CRC_LENGTH`, from `para.v` (8): CRC width.
- `CRC_POLY`, from `para.v`: generator polynomial, implicit MSB omitted.
- `CNT_WIDTH`, from `para.v`: bit-counter width, ≥ clog2(DATA_LENGTH+1).
- `ERR_CNT_WIDTH`, new in `para.v`, default 8: error-counter width.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_crc_i` in DATA_LENGTH+CRC_LENGTH: codeword, laid out as {data, crc}.
- `rx_crc_start` in 1: load request; sampled only in IDLE.
- `rx_err_clr` in 1: synchronous clear of `rx_err_cnt`.
- `rx_crc_busy` out 1: high while state ≠ IDLE.
- `rx_crc_vld` out 1: one-cycle result strobe.
- `rx_crc_ok` out 1: syndrome == 0; held until the next result.
- `rx_crc_err` out 1: syndrome ≠ 0; held until the next result.
- `rx_crc_syn` out CRC_LENGTH: computed CRC XOR received CRC; held.
- `rx_crc_data` out DATA_LENGTH: captured data field; held.
- `rx_err_cnt` out ERR_CNT_WIDTH: saturating count of failed codewords.

## Operation
FSM states: IDLE, CALC, CHK.
- **IDLE → CALC** on `rx_crc_start`:
  - load `div_reg` = {data, CRC_LENGTH zeros};
  - capture the received CRC into `crc_rx_reg` and the data into a data hold register;
  - clear the bit counter.
- **CALC**, one division step per cycle:
  - the upper CRC_LENGTH bits of `div_reg` take the next CRC_LENGTH bits (one position down), XORed with `CRC_POLY` when the current MSB is 1;
  - the lower DATA_LENGTH bits shift left, filling with 0;
  - the counter increments.
  - After the step with counter == DATA_LENGTH-1, go to CHK. CALC lasts exactly DATA_LENGTH cycles.
- **CHK** (one cycle), then → IDLE. The exit edge registers:
  - `rx_crc_syn` = remainder ^ `crc_rx_reg`;
  - `rx_crc_ok` = (syn == 0), `rx_crc_err` = (syn ≠ 0);
  - `rx_crc_data` = captured data;
  - `rx_crc_vld` = 1 for one cycle;
  - `rx_err_cnt` increments if err, saturating at all-ones.
- `rx_crc_start` in CALC or CHK is ignored. No restart, no queuing.
- `rx_err_clr`:
  - alone: counter → 0;
  - in the same cycle as an erroring CHK exit: counter → 1, so the new error is not lost;
  - with a passing result: counter → 0.
- Arithmetic is mod-2 only. The counter is unsigned, and the error counter never wraps.

## Timing
- Reset value of every output and register is 0; state = IDLE.
- Asserting `rst_n` mid-CALC or mid-CHK aborts the codeword. No `rx_crc_vld` is produced for it.
- Latency: with start sampled at edge E0, `rx_crc_vld` is high in the cycle after edge E0+DATA_LENGTH+1.
- Throughput: one codeword per DATA_LENGTH+2 cycles.
- `rx_crc_busy` is high from the cycle after E0 through the CHK cycle. It is low during the `rx_crc_vld` cycle.
- A start may be asserted in the `rx_crc_vld` cycle (FSM is in IDLE) and is accepted. Back-to-back codewords have no gap beyond CHK.
- `rx_crc_ok`, `rx_crc_err`, `rx_crc_syn` and `rx_crc_data` change only on the CHK exit edge or on reset.

## Structure
- `para.v` holds `DATA_LENGTH`, `CRC_LENGTH`, `CRC_POLY`, `CNT_WIDTH`, `ERR_CNT_WIDTH`, and the state encodings `RX_IDLE`/`RX_CALC`/`RX_CHK` (2 bits).
- Sub-module `crc_serial_div`: `div_reg` plus the one-step division datapath, with load/step controls and a remainder output. The transmit generator can later share it.
- The top level holds the FSM, bit counter, capture registers, compare and error counter.

## Test plan
Bench configuration: DATA_LENGTH=8, CRC_POLY=8'h07.
1. Reset then idle → all outputs 0 and `rx_crc_busy`=0.
2. Start with `rx_crc_i`=16'h0107 → `rx_crc_vld` pulses exactly 10 cycles after the start edge; ok=1, err=0, syn=8'h00, data=8'h01, `rx_err_cnt`=0.
3. Start with 16'hFFF3 (pass), then 16'h0106 (fail) → second result: err=1, syn=8'h01, `rx_err_cnt`=1.
4. Start re-asserted during CALC with a different codeword → ignored; the result is for the first word, with identical latency. Start in the `rx_crc_vld` cycle → accepted, next `rx_crc_vld` 10 cycles later.
5. Force 255 errors, then one more → `rx_err_cnt` stays 8'hFF. `rx_err_clr` coincident with an error result → `rx_err_cnt`=1.
6. `rst_n` pulsed low at cycle 4 of CALC → all outputs 0 immediately, no `rx_crc_vld`. A subsequent 16'h0000 → ok=1.
